// File: rtl/data_dispatcher_pkg.sv
// Shared definitions for the data_dispatcher slice: destination encodings and
// pointer sizing helpers used by the top level and its per-sink FIFOs.
package data_dispatcher_pkg;

  typedef enum logic [1:0] {
    DEST_A   = 2'd0,
    DEST_B   = 2'd1,
    DEST_C   = 2'd2,
    DEST_ALL = 2'd3
  } dest_e;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 64;
  localparam int PTR_W         = $clog2(DEFAULT_DEPTH);

  // Pointer width for an arbitrary FIFO depth; count needs one extra bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Synchronous first-word-fall-through FIFO used once per sink. Head reads as
// zero while empty; a push into an empty FIFO becomes visible the next cycle.
module dispatch_fifo
  import data_dispatcher_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_width(DEPTH):0] count,
  output logic [WIDTH-1:0]          head
);

  localparam int          AW         = ptr_width(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Refusal uses the pre-pop count, so a full FIFO never writes through a pop.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= din;
  end

  assign head = empty ? '0 : mem[rd_ptr];

  count_in_range: assert property (@(posedge clk) disable iff (rst)
    count <= FULL_COUNT);

  pointers_consistent: assert property (@(posedge clk) disable iff (rst)
    (count == '0 || count == FULL_COUNT) |-> (wr_ptr == rd_ptr));

endmodule

// File: rtl/data_dispatcher.sv
// One producer steered into three sink FIFOs (A/B/C) or all three at once.
// Handshake: a transfer happens on any edge where valid && grant are both high;
// the sender holds data/valid (and DestSel) until then, grant never looks at valid.
module data_dispatcher
  import data_dispatcher_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH      = DEFAULT_WIDTH
) (
  input  logic                                      CLK,
  input  logic                                      Reset,
  input  logic                                      i_DataValid_S,
  input  logic [WIDTH-1:0]                          i_DataIn_S,
  input  logic [1:0]                                i_DestSel_S,
  output logic                                      o_DataGrant_S,
  input  logic                                      i_DataGrant_A,
  input  logic                                      i_DataGrant_B,
  input  logic                                      i_DataGrant_C,
  output logic                                      o_DataValid_A,
  output logic                                      o_DataValid_B,
  output logic                                      o_DataValid_C,
  output logic [WIDTH-1:0]                          o_DataOut_A,
  output logic [WIDTH-1:0]                          o_DataOut_B,
  output logic [WIDTH-1:0]                          o_DataOut_C,
  output logic [3*(ptr_width(FIFO_DEPTH)+1)-1:0]    dbg_count
);

  localparam int CW = ptr_width(FIFO_DEPTH) + 1;

  logic          sel_a, sel_b, sel_c;
  logic          grant;
  logic          accept;
  logic          full_a, full_b, full_c;
  logic          empty_a, empty_b, empty_c;
  logic [CW-1:0] count_a, count_b, count_c;

  // Broadcast is all-or-nothing: it waits until every sink has room.
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    sel_c = 1'b0;
    grant = 1'b0;
    case (dest_e'(i_DestSel_S))
      DEST_A: begin
        sel_a = 1'b1;
        grant = !full_a;
      end
      DEST_B: begin
        sel_b = 1'b1;
        grant = !full_b;
      end
      DEST_C: begin
        sel_c = 1'b1;
        grant = !full_c;
      end
      DEST_ALL: begin
        sel_a = 1'b1;
        sel_b = 1'b1;
        sel_c = 1'b1;
        grant = !full_a && !full_b && !full_c;
      end
      default: grant = 1'b0;
    endcase
  end

  assign o_DataGrant_S = grant;
  assign accept        = i_DataValid_S && grant;

  dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk   (CLK),
    .rst   (Reset),
    .push  (accept && sel_a),
    .pop   (i_DataGrant_A),
    .din   (i_DataIn_S),
    .full  (full_a),
    .empty (empty_a),
    .count (count_a),
    .head  (o_DataOut_A)
  );

  dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk   (CLK),
    .rst   (Reset),
    .push  (accept && sel_b),
    .pop   (i_DataGrant_B),
    .din   (i_DataIn_S),
    .full  (full_b),
    .empty (empty_b),
    .count (count_b),
    .head  (o_DataOut_B)
  );

  dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_c (
    .clk   (CLK),
    .rst   (Reset),
    .push  (accept && sel_c),
    .pop   (i_DataGrant_C),
    .din   (i_DataIn_S),
    .full  (full_c),
    .empty (empty_c),
    .count (count_c),
    .head  (o_DataOut_C)
  );

  assign o_DataValid_A = !empty_a;
  assign o_DataValid_B = !empty_b;
  assign o_DataValid_C = !empty_c;

  // Occupancy observation, packed {C, B, A}.
  assign dbg_count = {count_c, count_b, count_a};

endmodule

// File: tb/tb_data_dispatcher.sv
// Bench for data_dispatcher: directed vectors with a per-sink expected-queue
// scoreboard, followed by a randomized soak of destinations and sink grants.
module tb_data_dispatcher;

  localparam int W  = 64;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          i_DataValid_S = 1'b0;
  logic [W-1:0]  i_DataIn_S = '0;
  logic [1:0]    i_DestSel_S = 2'd0;
  logic          o_DataGrant_S;
  logic          ga = 1'b0, gb = 1'b0, gc = 1'b0;
  logic          o_DataValid_A, o_DataValid_B, o_DataValid_C;
  logic [W-1:0]  o_DataOut_A, o_DataOut_B, o_DataOut_C;
  logic [3*CW-1:0] dbg_count;

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic [W-1:0] exp_q_c[$];

  int  vectors = 0;
  int  miscompares = 0;
  bit  rand_done = 1'b0;

  data_dispatcher #(.FIFO_DEPTH(8), .WIDTH(W)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .i_DataValid_S (i_DataValid_S),
    .i_DataIn_S    (i_DataIn_S),
    .i_DestSel_S   (i_DestSel_S),
    .o_DataGrant_S (o_DataGrant_S),
    .i_DataGrant_A (ga),
    .i_DataGrant_B (gb),
    .i_DataGrant_C (gc),
    .o_DataValid_A (o_DataValid_A),
    .o_DataValid_B (o_DataValid_B),
    .o_DataValid_C (o_DataValid_C),
    .o_DataOut_A   (o_DataOut_A),
    .o_DataOut_B   (o_DataOut_B),
    .o_DataOut_C   (o_DataOut_C),
    .dbg_count     (dbg_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_push(input logic [W-1:0] d, input logic [1:0] dest);
    if (dest == 2'd0 || dest == 2'd3) exp_q_a.push_back(d);
    if (dest == 2'd1 || dest == 2'd3) exp_q_b.push_back(d);
    if (dest == 2'd2 || dest == 2'd3) exp_q_c.push_back(d);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one word and hold it until the dispatcher grants it.
  task automatic send(input logic [W-1:0] d, input logic [1:0] dest);
    int waited = 0;
    i_DataValid_S = 1'b1;
    i_DataIn_S    = d;
    i_DestSel_S   = dest;
    while (1) begin
      @(negedge CLK);
      if (o_DataGrant_S) begin
        expect_push(d, dest);
        break;
      end
      waited++;
      if (waited >= 200) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    tick();
    i_DataValid_S = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt(input int sink);
    return dbg_count[sink*CW +: CW];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (!Reset) begin
      if (o_DataValid_A && ga) begin
        if (exp_q_a.size() == 0) check("a_unexpected_word", o_DataOut_A, 64'd0);
        else check("a_order", o_DataOut_A, exp_q_a.pop_front());
      end
      if (o_DataValid_B && gb) begin
        if (exp_q_b.size() == 0) check("b_unexpected_word", o_DataOut_B, 64'd0);
        else check("b_order", o_DataOut_B, exp_q_b.pop_front());
      end
      if (o_DataValid_C && gc) begin
        if (exp_q_c.size() == 0) check("c_unexpected_word", o_DataOut_C, 64'd0);
        else check("c_order", o_DataOut_C, exp_q_c.pop_front());
      end
      if (!o_DataValid_A) check("a_idle_zero", o_DataOut_A, 64'd0);
      if (!o_DataValid_B) check("b_idle_zero", o_DataOut_B, 64'd0);
      if (!o_DataValid_C) check("c_idle_zero", o_DataOut_C, 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_valids", {o_DataValid_A, o_DataValid_B, o_DataValid_C}, 64'd0);
    check("rst_out_a", o_DataOut_A, 64'd0);
    check("rst_grant", o_DataGrant_S, 64'd1);
    check("rst_counts", dbg_count, 64'd0);
    tick();
    Reset = 1'b0;
    tick();

    // A stream: one word per cycle, visible the cycle after accept
    ga = 1'b1;
    send(64'h11, 2'd0);
    check("a_lat_valid_11", o_DataValid_A, 64'd1);
    check("a_lat_data_11", o_DataOut_A, 64'h11);
    send(64'h22, 2'd0);
    check("a_lat_data_22", o_DataOut_A, 64'h22);
    send(64'h33, 2'd0);
    check("a_lat_data_33", o_DataOut_A, 64'h33);
    check("bc_valid_quiet", {o_DataValid_B, o_DataValid_C}, 64'd0);
    tick();
    check("a_drained", o_DataValid_A, 64'd0);
    ga = 1'b0;

    // Fill B, grant depends on DestSel only
    for (int i = 0; i < 8; i++) send(64'hB0 + 64'(i), 2'd1);
    check("b_count_full", cnt(1), 64'd8);
    @(negedge CLK);
    i_DestSel_S = 2'd1; #1 check("grant_dest_b_full", o_DataGrant_S, 64'd0);
    i_DestSel_S = 2'd0; #1 check("grant_dest_a", o_DataGrant_S, 64'd1);
    i_DestSel_S = 2'd2; #1 check("grant_dest_c", o_DataGrant_S, 64'd1);
    i_DestSel_S = 2'd3; #1 check("grant_bcast_b_full", o_DataGrant_S, 64'd0);
    tick();
    gb = 1'b1;
    i_DataValid_S = 1'b1; i_DataIn_S = 64'hB8; i_DestSel_S = 2'd1;
    @(negedge CLK);
    check("b_full_pop_refuses", o_DataGrant_S, 64'd0);
    tick();
    gb = 1'b0;
    @(negedge CLK);
    check("b_grant_after_pop", o_DataGrant_S, 64'd1);
    expect_push(64'hB8, 2'd1);
    tick();
    i_DataValid_S = 1'b0;
    check("b_count_refull", cnt(1), 64'd8);
    gb = 1'b1;
    repeat (10) tick();
    gb = 1'b0;
    check("b_count_drained", cnt(1), 64'd0);

    // Broadcast blocked by full C
    for (int i = 0; i < 8; i++) send(64'hC0 + 64'(i), 2'd2);
    i_DataValid_S = 1'b1; i_DataIn_S = 64'hAB; i_DestSel_S = 2'd3;
    @(negedge CLK);
    check("bcast_blocked", o_DataGrant_S, 64'd0);
    tick();
    check("bcast_no_partial", dbg_count, {4'd8, 4'd0, 4'd0});
    gc = 1'b1;
    @(negedge CLK);
    check("bcast_blocked_on_pop", o_DataGrant_S, 64'd0);
    tick();
    gc = 1'b0;
    @(negedge CLK);
    check("bcast_granted", o_DataGrant_S, 64'd1);
    expect_push(64'hAB, 2'd3);
    tick();
    i_DataValid_S = 1'b0;
    check("bcast_counts", dbg_count, {4'd8, 4'd1, 4'd1});
    check("bcast_a_data", o_DataOut_A, 64'hAB);
    check("bcast_b_data", o_DataOut_B, 64'hAB);
    ga = 1'b1; gb = 1'b1; gc = 1'b1;
    repeat (12) tick();
    ga = 1'b0; gb = 1'b0; gc = 1'b0;
    check("all_drained", dbg_count, 64'd0);

    // Full A, push and pop in the same cycle
    for (int i = 0; i < 8; i++) send(64'hA0 + 64'(i), 2'd0);
    ga = 1'b1;
    i_DataValid_S = 1'b1; i_DataIn_S = 64'hA8; i_DestSel_S = 2'd0;
    @(negedge CLK);
    check("a_full_push_refused", o_DataGrant_S, 64'd0);
    tick();
    ga = 1'b0;
    check("a_count_8_to_7", cnt(0), 64'd7);
    @(negedge CLK);
    check("a_push_next_cycle", o_DataGrant_S, 64'd1);
    expect_push(64'hA8, 2'd0);
    tick();
    i_DataValid_S = 1'b0;
    check("a_count_back_8", cnt(0), 64'd8);
    ga = 1'b1;
    repeat (10) tick();
    ga = 1'b0;

    // Reset flush with 5 words in each FIFO
    for (int i = 0; i < 5; i++) send(64'h50 + 64'(i), 2'd3);
    check("pre_flush_counts", dbg_count, {4'd5, 4'd5, 4'd5});
    Reset = 1'b1;
    exp_q_a.delete(); exp_q_b.delete(); exp_q_c.delete();
    tick();
    check("flush_valids", {o_DataValid_A, o_DataValid_B, o_DataValid_C}, 64'd0);
    check("flush_grant", o_DataGrant_S, 64'd1);
    check("flush_counts", dbg_count, 64'd0);
    check("flush_out_c", o_DataOut_C, 64'd0);
    Reset = 1'b0;
    ga = 1'b1; gb = 1'b1; gc = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("no_stale_words", {o_DataValid_A, o_DataValid_B, o_DataValid_C}, 64'd0);
    end
    tick();

    // Randomized destinations and sink grants
    fork
      begin
        for (int i = 0; i < 1500; i++)
          send({$urandom, $urandom}, 2'($urandom_range(0, 3)));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          ga = ($urandom_range(0, 3) != 0);
          gb = ($urandom_range(0, 3) != 0);
          gc = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    ga = 1'b1; gb = 1'b1; gc = 1'b1;
    repeat (20) tick();
    check("final_queues_empty", 64'(exp_q_a.size() + exp_q_b.size() + exp_q_c.size()), 64'd0);
    check("final_counts", dbg_count, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
